// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit cpu: fetches instructions over a
// req/ack ROM handshake, owns PC and carry flag, and strobes datapath controls.
module cpu_sequencer #(
    parameter logic [3:0] RESET_PC      = 4'h0,
    parameter logic [7:0] FETCH_TIMEOUT = 8'd16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       run,
    input  logic       step,
    output logic       rom_req,
    output logic [3:0] rom_addr,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    input  logic       alu_carry,
    output logic       select_a,
    output logic       select_b,
    output logic       load0,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic [3:0] im,
    output logic [3:0] pc,
    output logic       cf,
    output logic       halted,
    output logic       fault,
    output logic       instr_done
);

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

    state_t     state;
    logic [3:0] pc_q;
    logic       cf_q;
    logic       fault_q;
    logic       step_mode;
    logic [7:0] wait_cnt;
    logic [7:0] ir;
    logic       rom_req_q;
    logic [1:0] sel_q;
    logic [3:0] im_q;
    logic [3:0] load_q;
    logic       instr_done_q;
    logic       halted_q;

    logic [1:0] dec_sel;
    logic [3:0] dec_im;
    logic [3:0] dec_load;

    // Decode straight from rom_data so the EXEC-cycle controls come out of registers.
    always_comb begin
        dec_sel  = 2'b11;
        dec_im   = '0;
        dec_load = '0;
        case (rom_data[7:4])
            4'h0: begin dec_sel = 2'b00; dec_im = rom_data[3:0]; dec_load = 4'b0001; end
            4'h1: begin dec_sel = 2'b01; dec_load = 4'b0001; end
            4'h2: begin dec_sel = 2'b10; dec_load = 4'b0001; end
            4'h3: begin dec_sel = 2'b11; dec_im = rom_data[3:0]; dec_load = 4'b0001; end
            4'h4: begin dec_sel = 2'b00; dec_load = 4'b0010; end
            4'h5: begin dec_sel = 2'b01; dec_im = rom_data[3:0]; dec_load = 4'b0010; end
            4'h6: begin dec_sel = 2'b10; dec_load = 4'b0010; end
            4'h7: begin dec_sel = 2'b11; dec_im = rom_data[3:0]; dec_load = 4'b0010; end
            4'h9: begin dec_sel = 2'b01; dec_load = 4'b0100; end
            4'hB: begin dec_sel = 2'b11; dec_im = rom_data[3:0]; dec_load = 4'b0100; end
            4'hD: begin dec_sel = 2'b00; dec_load = 4'b1000; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state        <= S_HALT;
            pc_q         <= RESET_PC;
            cf_q         <= 1'b0;
            fault_q      <= 1'b0;
            step_mode    <= 1'b0;
            wait_cnt     <= '0;
            ir           <= '0;
            rom_req_q    <= 1'b0;
            sel_q        <= 2'b11;
            im_q         <= '0;
            load_q       <= '0;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b1;
        end else begin
            // Controls idle at zero+0 unless the FETCH->EXEC transition below overrides them.
            sel_q        <= 2'b11;
            im_q         <= '0;
            load_q       <= '0;
            instr_done_q <= 1'b0;
            case (state)
                S_HALT: begin
                    if ((run || step) && !fault_q) begin
                        state     <= S_FETCH;
                        step_mode <= ~run;
                        rom_req_q <= 1'b1;
                        halted_q  <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (rom_ack) begin
                        ir           <= rom_data;
                        state        <= S_EXEC;
                        rom_req_q    <= 1'b0;
                        sel_q        <= dec_sel;
                        im_q         <= dec_im;
                        load_q       <= dec_load;
                        instr_done_q <= 1'b1;
                    end else if (FETCH_TIMEOUT != 8'd0 && wait_cnt == FETCH_TIMEOUT - 8'd1) begin
                        fault_q   <= 1'b1;
                        state     <= S_HALT;
                        rom_req_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    case (ir[7:4])
                        4'hE:    pc_q <= cf_q ? pc_q + 4'd1 : ir[3:0];
                        4'hF:    pc_q <= ir[3:0];
                        default: pc_q <= pc_q + 4'd1;
                    endcase
                    cf_q <= (|load_q) ? alu_carry : 1'b0;
                    if (run && !step_mode) begin
                        state     <= S_FETCH;
                        rom_req_q <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_HALT;
                    rom_req_q <= 1'b0;
                    halted_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rom_req    = rom_req_q;
    assign rom_addr   = pc_q;
    assign select_a   = sel_q[0];
    assign select_b   = sel_q[1];
    assign load0      = load_q[0];
    assign load1      = load_q[1];
    assign load2      = load_q[2];
    assign load3      = load_q[3];
    assign im         = im_q;
    assign pc         = pc_q;
    assign cf         = cf_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign instr_done = instr_done_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a small datapath supplies alu_carry, and an
// instruction-level model of the 4-bit cpu predicts controls, pc and cf.
module tb_cpu_sequencer;

    localparam logic [3:0] RESET_PC      = 4'h0;
    localparam logic [7:0] FETCH_TIMEOUT = 8'd16;

    logic clk = 1'b0;
    logic n_reset, run, step, rom_ack, alu_carry;
    logic [7:0] rom_data;
    logic rom_req, select_a, select_b, load0, load1, load2, load3;
    logic halted, fault, instr_done, cf;
    logic [3:0] rom_addr, im, pc;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [7:0] rom [16];
    logic [3:0] dp [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] m_reg [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] m_pc;
    logic       m_cf;

    cpu_sequencer #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
        .clk(clk), .n_reset(n_reset), .run(run), .step(step),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .alu_carry(alu_carry), .select_a(select_a), .select_b(select_b),
        .load0(load0), .load1(load1), .load2(load2), .load3(load3), .im(im),
        .pc(pc), .cf(cf), .halted(halted), .fault(fault), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: source mux + adder, registers written by the load strobes.
    logic [3:0] dp_src;
    logic [4:0] dp_sum;
    always_comb begin
        case ({select_b, select_a})
            2'b00:   dp_src = dp[0];
            2'b01:   dp_src = dp[1];
            2'b10:   dp_src = dp[2];
            default: dp_src = 4'h0;
        endcase
        dp_sum    = {1'b0, dp_src} + {1'b0, im};
        alu_carry = dp_sum[4];
    end
    always @(posedge clk) begin
        if (load0) dp[0] <= dp_sum[3:0];
        if (load1) dp[1] <= dp_sum[3:0];
        if (load2) dp[2] <= dp_sum[3:0];
        if (load3) dp[3] <= dp_sum[3:0];
    end

    always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

    typedef struct {
        bit ld;    // writes a register
        int dst;   // 0..3 = A..D
        int src;   // 0..2 = A..C, 3 = constant zero
        bit imm;   // adds the immediate
    } op_t;

    function automatic op_t iss_op(input logic [3:0] op);
        op_t o = '{0, 0, 3, 0};
        case (op)
            4'h0: o = '{1, 0, 0, 1};
            4'h1: o = '{1, 0, 1, 0};
            4'h2: o = '{1, 0, 2, 0};
            4'h3: o = '{1, 0, 3, 1};
            4'h4: o = '{1, 1, 0, 0};
            4'h5: o = '{1, 1, 1, 1};
            4'h6: o = '{1, 1, 2, 0};
            4'h7: o = '{1, 1, 3, 1};
            4'h9: o = '{1, 2, 1, 0};
            4'hB: o = '{1, 2, 3, 1};
            4'hD: o = '{1, 3, 0, 0};
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (rom_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {7'd0, rom_req}, 8'd1);
    endtask

    // One instruction: ack after 'delay' FETCH cycles, check EXEC controls, then pc/cf.
    task automatic run_instr(input int delay);
        op_t        o;
        logic [7:0] ins;
        logic [4:0] sum;
        logic [3:0] v, exp_load;
        wait_req();
        if (rom_req !== 1'b1) return;
        chk("rom_addr", {4'd0, rom_addr}, {4'd0, m_pc});
        repeat (delay) @(negedge clk);
        ins      = rom[m_pc];
        rom_ack  = 1'b1;
        rom_data = ins;
        @(negedge clk);
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
        o        = iss_op(ins[7:4]);
        v        = (o.src == 3) ? 4'h0 : m_reg[o.src];
        sum      = {1'b0, v} + {1'b0, (o.imm ? ins[3:0] : 4'h0)};
        exp_load = o.ld ? 4'(1 << o.dst) : 4'h0;
        chk("instr_done", {7'd0, instr_done}, 8'd1);
        chk("loads", {4'd0, load3, load2, load1, load0}, {4'd0, exp_load});
        chk("im", {4'd0, im}, {4'd0, (o.imm ? ins[3:0] : 4'h0)});
        if (o.ld) chk("select", {6'd0, select_b, select_a}, 8'(o.src));
        else      chk("select", {6'd0, select_b, select_a}, 8'd3);
        if (ins[7:4] == 4'hF || (ins[7:4] == 4'hE && !m_cf)) m_pc = ins[3:0];
        else m_pc = m_pc + 4'd1;
        if (o.ld) m_reg[o.dst] = sum[3:0];
        m_cf = o.ld ? sum[4] : 1'b0;
        @(negedge clk);
        chk("pc", {4'd0, pc}, {4'd0, m_pc});
        chk("cf", {7'd0, cf}, {7'd0, m_cf});
    endtask

    initial begin
        int base;
        n_reset = 1'b0; run = 1'b0; step = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        repeat (3) @(negedge clk);
        chk("rst_halted", {7'd0, halted}, 8'd1);
        chk("rst_req", {7'd0, rom_req}, 8'd0);
        chk("rst_pc", {4'd0, pc}, {4'd0, RESET_PC});
        chk("rst_cf", {7'd0, cf}, 8'd0);
        chk("rst_fault", {7'd0, fault}, 8'd0);
        chk("rst_sel", {6'd0, select_b, select_a}, 8'd3);
        chk("rst_im", {4'd0, im}, 8'd0);
        chk("rst_loads", {4'd0, load3, load2, load1, load0}, 8'd0);
        chk("rst_done", {7'd0, instr_done}, 8'd0);
        m_pc = RESET_PC; m_cf = 1'b0;

        // Directed program: MOV A,5; MOV A,3; ADD A,F; JNC 0; JMP 7; ..7: JMP F; ..F: NOP
        rom[0] = 8'h35; rom[1] = 8'h33; rom[2] = 8'h0F; rom[3] = 8'hE0;
        rom[4] = 8'hF7; rom[7] = 8'hFF; rom[15] = 8'h80;
        n_reset = 1'b1; run = 1'b1;
        run_instr(0);
        chk("mov_a5_pc", {4'd0, pc}, 8'd1);
        run_instr(2);
        run_instr(1);
        chk("add_cf", {7'd0, cf}, 8'd1);
        run_instr(0);
        chk("jnc_pc", {4'd0, pc}, 8'd4);
        chk("jnc_cf", {7'd0, cf}, 8'd0);
        run_instr(3);
        chk("jmp_pc", {4'd0, pc}, 8'd7);
        run_instr(0);
        run = 1'b0;
        run_instr(1);
        chk("wrap_pc", {4'd0, pc}, 8'd0);
        chk("run_off_halt", {7'd0, halted}, 8'd1);

        // Single step from HALT
        base = done_cnt;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        run_instr(1);
        repeat (4) @(negedge clk);
        chk("step_done_cnt", 8'(done_cnt - base), 8'd1);
        chk("step_halted", {7'd0, halted}, 8'd1);
        chk("step_pc", {4'd0, pc}, 8'd1);

        // Random program in free-run with random ack latency
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 39) run = 1'b0;
            run_instr(int'($urandom_range(0, 3)));
        end
        chk("rand_halted", {7'd0, halted}, 8'd1);

        // Reset while a fetch is outstanding
        run = 1'b1;
        wait_req();
        n_reset = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", {7'd0, rom_req}, 8'd0);
        chk("mid_rst_pc", {4'd0, pc}, {4'd0, RESET_PC});
        chk("mid_rst_cf", {7'd0, cf}, 8'd0);
        chk("mid_rst_halted", {7'd0, halted}, 8'd1);
        n_reset = 1'b1;
        m_pc = RESET_PC; m_cf = 1'b0;

        // Fetch timeout: no ack ever
        run = 1'b1;
        wait_req();
        repeat (int'(FETCH_TIMEOUT) - 1) @(negedge clk);
        chk("to_early_fault", {7'd0, fault}, 8'd0);
        chk("to_early_req", {7'd0, rom_req}, 8'd1);
        @(negedge clk);
        chk("to_fault", {7'd0, fault}, 8'd1);
        chk("to_halted", {7'd0, halted}, 8'd1);
        chk("to_req", {7'd0, rom_req}, 8'd0);
        repeat (5) @(negedge clk);
        chk("to_sticky_fault", {7'd0, fault}, 8'd1);
        chk("to_run_ignored", {7'd0, rom_req}, 8'd0);
        chk("to_stay_halted", {7'd0, halted}, 8'd1);
        n_reset = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("to_rst_clears", {7'd0, fault}, 8'd0);
        n_reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
